// File: rtl/aes_axi_pkg.sv
// Shared types and helpers for the AES core AXI4 slave front end.
// Burst/response encodings, FSM state types and burst legality checks.
package aes_axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Bursts that get SLVERR regardless of how the data phase goes.
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        return (size > AXI_SIZE_4B) || (burst == 2'b11) ||
               ((burst == WRAP) && !wrap_len_ok(len));
    endfunction

    // Bursts whose write beats must not touch the buffer.
    function automatic logic burst_suppress(input logic [2:0] size, input logic [1:0] burst);
        return (size > AXI_SIZE_4B) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/aes_core_encrypt_s00_axi_slave_if.sv
// AXI4 full link between the S00_AXI master and the AES core slave.
// Handshake and payload signals for all five channels.
interface aes_core_encrypt_s00_axi_slave_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/aes_axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
// Illegal WRAP lengths and the reserved burst type advance as INCR.
module aes_axi_burst_addr_gen
    import aes_axi_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    logic [15:0]       wrap_bytes;
    logic [15:0]       wrap_mask;

    assign step       = ADDR_W'(1) << size;
    assign incr       = addr + step;
    assign wrap_bytes = (16'(len) + 16'd1) << size;
    assign wrap_mask  = wrap_bytes - 16'd1;
    // A wrap window larger than the address space degenerates to plain modulo.
    assign mask       = (|wrap_mask[15:ADDR_W]) ? '1 : wrap_mask[ADDR_W-1:0];

    always_comb begin
        next_addr = incr;
        if (burst == FIXED) begin
            next_addr = addr;
        end else if ((burst == WRAP) && wrap_len_ok(len)) begin
            next_addr = (addr & ~mask) | (incr & mask);
        end
    end

endmodule

// File: rtl/aes_core_encrypt_s00_axi_slave.sv
// AXI4 burst slave terminating S00_AXI into the AES key/plaintext/ciphertext
// word buffer, with independent single-outstanding write and read channels.
module aes_core_encrypt_s00_axi_slave
    import aes_axi_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    aes_core_encrypt_s00_axi_slave_if.slave s00_axi,
    input  logic [C_S_AXI_ADDR_WIDTH-3:0]   buf_rd_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   buf_rd_data
);

    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int DEPTH  = 1 << (AW - 2);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    wr_state_t                   w_state;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id;
    logic [AW-1:0]               w_addr;
    logic [AW-1:0]               w_next;
    logic [7:0]                  w_len;
    logic [7:0]                  w_beat;
    logic [2:0]                  w_size;
    logic [1:0]                  w_burst;
    logic                        w_err;
    logic                        w_suppress;
    logic                        aw_hs;
    logic                        w_hs;
    logic                        w_last_beat;

    rd_state_t                   r_state;
    logic [AW-1:0]               r_addr;
    logic [AW-1:0]               r_next;
    logic [7:0]                  r_len;
    logic [7:0]                  r_beat;
    logic [2:0]                  r_size;
    logic [1:0]                  r_burst;
    logic                        ar_hs;
    logic                        r_hs;

    assign aw_hs       = s00_axi.awvalid && s00_axi.awready;
    assign w_hs        = s00_axi.wvalid && s00_axi.wready;
    assign ar_hs       = s00_axi.arvalid && s00_axi.arready;
    assign r_hs        = s00_axi.rvalid && s00_axi.rready;
    assign w_last_beat = (w_beat == w_len);
    assign buf_rd_data = mem[buf_rd_idx];

    aes_axi_burst_addr_gen #(.ADDR_W(AW)) u_wr_addr_gen (
        .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next)
    );

    aes_axi_burst_addr_gen #(.ADDR_W(AW)) u_rd_addr_gen (
        .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next)
    );

    // Write channel control
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state         <= W_IDLE;
            s00_axi.awready <= 1'b1;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
            s00_axi.bresp   <= OKAY;
            s00_axi.bid     <= '0;
            w_beat          <= '0;
            w_err           <= 1'b0;
            w_suppress      <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        s00_axi.awready <= 1'b0;
                        s00_axi.wready  <= 1'b1;
                        w_beat          <= '0;
                        w_err           <= burst_err(s00_axi.awsize, s00_axi.awburst, s00_axi.awlen);
                        w_suppress      <= burst_suppress(s00_axi.awsize, s00_axi.awburst);
                        w_state         <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        // Whichever of WLAST or the beat count comes first ends the burst.
                        if (s00_axi.wlast || w_last_beat) begin
                            s00_axi.wready <= 1'b0;
                            s00_axi.bvalid <= 1'b1;
                            s00_axi.bid    <= w_id;
                            s00_axi.bresp  <= (w_err || (s00_axi.wlast != w_last_beat)) ? SLVERR : OKAY;
                            w_state        <= W_RESP;
                        end else begin
                            w_beat <= w_beat + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s00_axi.bready) begin
                        s00_axi.bvalid  <= 1'b0;
                        s00_axi.awready <= 1'b1;
                        w_state         <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            w_id    <= s00_axi.awid;
            w_addr  <= s00_axi.awaddr;
            w_len   <= s00_axi.awlen;
            w_size  <= s00_axi.awsize;
            w_burst <= s00_axi.awburst;
        end else if (w_hs) begin
            w_addr <= w_next;
        end
    end

    // Buffer write port; WREADY drops asynchronously on reset so nothing lands mid-reset.
    always_ff @(posedge ACLK) begin
        if (w_hs && !w_suppress) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s00_axi.wstrb[b]) begin
                    mem[w_addr[AW-1:2]][8*b +: 8] <= s00_axi.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read channel control; the registered buffer read returns pre-write data on collision.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state         <= R_IDLE;
            s00_axi.arready <= 1'b1;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rlast   <= 1'b0;
            s00_axi.rresp   <= OKAY;
            s00_axi.rid     <= '0;
            s00_axi.rdata   <= '0;
            r_beat          <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s00_axi.arready <= 1'b0;
                        s00_axi.rvalid  <= 1'b1;
                        s00_axi.rid     <= s00_axi.arid;
                        s00_axi.rdata   <= mem[s00_axi.araddr[AW-1:2]];
                        s00_axi.rresp   <= burst_err(s00_axi.arsize, s00_axi.arburst, s00_axi.arlen) ? SLVERR : OKAY;
                        s00_axi.rlast   <= (s00_axi.arlen == 8'd0);
                        r_beat          <= '0;
                        r_state         <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (s00_axi.rlast) begin
                            s00_axi.rvalid  <= 1'b0;
                            s00_axi.rlast   <= 1'b0;
                            s00_axi.arready <= 1'b1;
                            r_state         <= R_IDLE;
                        end else begin
                            s00_axi.rdata <= mem[r_next[AW-1:2]];
                            s00_axi.rlast <= ((r_beat + 8'd1) == r_len);
                            r_beat        <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ar_hs) begin
            r_addr  <= s00_axi.araddr;
            r_len   <= s00_axi.arlen;
            r_size  <= s00_axi.arsize;
            r_burst <= s00_axi.arburst;
        end else if (r_hs) begin
            r_addr <= r_next;
        end
    end

endmodule
